// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin, message-locked arbiter sharing one RS232 byte
// transmitter among N_REQ valid/ready byte streams, with an idle-owner timeout.
module rs232_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 104166
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               locked,
  output logic               err_timeout,
  output logic [ID_W-1:0]    err_id
);

  localparam int unsigned      CNT_W      = 32;
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   scan_sel;
  logic              scan_hit;
  logic [ID_W-1:0]   sel;
  logic              sel_valid;
  logic [7:0]        sel_data;
  logic              sel_last;
  logic              accept;
  logic              idle_tick;
  logic              expire;
  logic [CNT_W-1:0]  idle_cnt;

  // Index increment modulo N_REQ (N_REQ need not be a power of two)
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (32'(v) == N_REQ - 1) return '0;
    return v + ID_W'(1);
  endfunction

  // Round-robin scan: first valid requester starting at rr_ptr
  always_comb begin
    scan_sel = rr_ptr;
    scan_hit = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!scan_hit && req_valid[(32'(rr_ptr) + i) % N_REQ]) begin
        scan_sel = ID_W'((32'(rr_ptr) + i) % N_REQ);
        scan_hit = 1'b1;
      end
    end
  end

  // A locked message pins selection to its owner; otherwise use the scan result
  always_comb begin
    sel       = locked ? grant_id : scan_sel;
    sel_valid = req_valid[sel];
    sel_data  = req_data[8*32'(sel) +: 8];
    sel_last  = req_last[sel];
  end

  assign accept    = |(req_valid & req_ready);
  assign idle_tick = (state == ST_IDLE) && locked && !req_valid[grant_id];
  assign expire    = TIMEOUT_EN && idle_tick && (idle_cnt == CNT_LAST);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept)   state_next = ST_LAUNCH;
      ST_LAUNCH:               state_next = ST_WAIT;
      ST_WAIT:   if (!tx_busy) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: a single ready bit, only while idle and the transmitter is free
  always_comb begin
    req_ready = '0;
    if (!reset && (state == ST_IDLE) && !tx_busy && sel_valid) req_ready[sel] = 1'b1;
  end

  // Byte capture, start pulse, message lock, round-robin pointer and idle timeout
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      locked      <= 1'b0;
      rr_ptr      <= '0;
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
      err_id      <= '0;
    end else begin
      tx_start    <= accept;
      err_timeout <= 1'b0;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= sel;
        idle_cnt <= '0;
        if (sel_last) begin
          locked <= 1'b0;
          rr_ptr <= wrap_inc(sel);
        end else begin
          locked <= 1'b1;
        end
      end else if (expire) begin
        locked      <= 1'b0;
        err_timeout <= 1'b1;
        err_id      <= grant_id;
        rr_ptr      <= wrap_inc(grant_id);
        idle_cnt    <= '0;
      end else if (state != ST_IDLE) begin
        idle_cnt <= '0;
      end else if (idle_tick) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter with a small TX model (3 busy cycles per frame).
module tb_rs232_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned TMO   = 16;
  localparam int          FRAME = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic [IDW-1:0]   grant_id;
  logic             locked;
  logic             err_timeout;
  logic [IDW-1:0]   err_id;

  always #5 clock = ~clock;

  rs232_tx_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked),
    .err_timeout(err_timeout), .err_id(err_id)
  );

  // Transmitter model: busy for FRAME cycles starting the cycle after tx_start
  logic busy_force = 1'b0;
  int   busy_cnt   = 0;
  always @(posedge clock) begin
    if (tx_start === 1'b1)  busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_force | (busy_cnt != 0);

  // Per-requester byte queues
  logic [7:0] mem_d [N][8];
  logic       mem_l [N][8];
  int         head  [N];
  int         tail  [N];

  // Observation logs
  int         acc_id[$];
  int         acc_cyc[$];
  logic [7:0] txd[$];
  logic       lck[$];
  int         err_cyc[$];
  int         err_idq[$];
  logic       err_lck[$];

  int n_tests = 0, n_fail = 0;
  int ready_multi = 0, ready_busy = 0, err_total = 0, cyc = 0;

  logic [N-1:0]   s_ready;
  logic           s_start, s_locked, s_err;
  logic [7:0]     s_data;
  logic [IDW-1:0] s_grant;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int acc_at(input int k);
    return (k < acc_id.size()) ? acc_id[k] : -1;
  endfunction
  function automatic int cyc_at(input int k);
    return (k < acc_cyc.size()) ? acc_cyc[k] : -1000;
  endfunction
  function automatic logic [31:0] txd_at(input int k);
    return (k < txd.size()) ? 32'(txd[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] lck_at(input int k);
    return (k < lck.size()) ? 32'(lck[k]) : 32'hFFFF_FFFF;
  endfunction

  task automatic push(input int i, input logic [7:0] d, input logic l);
    if (tail[i] < 8) begin
      mem_d[i][tail[i]] = d;
      mem_l[i][tail[i]] = l;
      tail[i]++;
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    acc_id.delete(); acc_cyc.delete(); txd.delete(); lck.delete();
    err_cyc.delete(); err_idq.delete(); err_lck.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = mem_d[i][head[i]];
        req_last[i]         = mem_l[i][head[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, log handshakes, then update inputs after the edge
  task automatic tick();
    @(negedge clock);
    cyc++;
    s_ready  = req_ready;
    s_start  = tx_start;
    s_data   = tx_data;
    s_locked = locked;
    s_grant  = grant_id;
    s_err    = err_timeout;
    if ($countones(req_ready) > 1) ready_multi++;
    if ((req_ready != '0) && tx_busy) ready_busy++;
    if (err_timeout === 1'b1) begin
      err_total++;
      err_cyc.push_back(cyc);
      err_idq.push_back(int'(err_id));
      err_lck.push_back(locked);
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] === 1'b1) begin
        acc_id.push_back(i);
        acc_cyc.push_back(cyc);
        head[i]++;
      end
    end
    if (tx_start === 1'b1) begin
      txd.push_back(tx_data);
      lck.push_back(locked);
    end
    @(posedge clock);
    #1;
    drive();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (acc_id.size() < n && b > 0) begin
      tick();
      b--;
    end
    check(tag, 32'(acc_id.size()), 32'(n));
  endtask

  task automatic settle();
    repeat (10) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  logic [7:0] exp_d [5];
  int         exp_i [5];

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_logs();

    // Reset state, with a request pending (ready must stay low during reset)
    push(0, 8'h55, 1'b1);
    drive();
    tick();
    tick();
    check("rst_ready",  32'(s_ready),  32'd0);
    check("rst_start",  32'(s_start),  32'd0);
    check("rst_data",   32'(s_data),   32'd0);
    check("rst_locked", 32'(s_locked), 32'd0);
    check("rst_grant",  32'(s_grant),  32'd0);
    check("rst_err",    32'(s_err),    32'd0);

    // 1: single byte, start pulse next cycle, second accept only after busy falls
    reset = 1'b0;
    tick();
    check("t1_ready", 32'(s_ready), 32'h1);
    push(0, 8'h66, 1'b1);
    drive();
    tick();
    check("t1_start",        32'(s_start), 32'd1);
    check("t1_data",         32'(s_data),  32'h55);
    check("t1_ready_launch", 32'(s_ready), 32'd0);
    run_until("t1_accepts", 2, 50);
    check("t1_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd6);
    settle();
    check("t1_data2", txd_at(1), 32'h66);

    // 2: all four valid, single-byte messages -> 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_logs();
    push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1); push(2, 8'hB2, 1'b1);
    push(3, 8'hB3, 1'b1); push(0, 8'hB4, 1'b1);
    drive();
    run_until("t2_accepts", 5, 100);
    settle();
    exp_i = '{0, 1, 2, 3, 0};
    exp_d = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_id%0d", k),   32'(acc_at(k)), 32'(exp_i[k]));
      check($sformatf("t2_data%0d", k), txd_at(k),      32'(exp_d[k]));
    end
    check("t2_locked", 32'(s_locked), 32'd0);
    check("t2_grant",  32'(s_grant),  32'd0);

    // 3: req1 three-byte message not interleaved with req2
    clear_logs();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(2, 8'hC2, 1'b1);
    drive();
    run_until("t3_accepts", 4, 100);
    settle();
    exp_i[0:3] = '{1, 1, 1, 2};
    exp_d[0:3] = '{8'hA1, 8'hA2, 8'hA3, 8'hC2};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_id%0d", k),   32'(acc_at(k)), 32'(exp_i[k]));
      check($sformatf("t3_data%0d", k), txd_at(k),      32'(exp_d[k]));
      check($sformatf("t3_lock%0d", k), lck_at(k),      (k < 2) ? 32'd1 : 32'd0);
    end

    // 4: req3 stalls mid-message, req0 starves until the timeout frees the lock
    clear_logs();
    push(3, 8'h10, 1'b0);
    push(0, 8'h20, 1'b1);
    drive();
    run_until("t4_accepts", 2, 100);
    settle();
    check("t4_id0",     32'(acc_at(0)), 32'd3);
    check("t4_id1",     32'(acc_at(1)), 32'd0);
    check("t4_errcnt",  32'(err_cyc.size()), 32'd1);
    if (err_cyc.size() == 1) begin
      check("t4_err_at",  32'(err_cyc[0] - cyc_at(0)), 32'd22);
      check("t4_err_id",  32'(err_idq[0]), 32'd3);
      check("t4_err_lck", 32'(err_lck[0]), 32'd0);
    end
    check("t4_acc_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd22);
    check("t4_data1",   txd_at(1), 32'h20);

    // 5: transmitter held busy for 100 cycles
    clear_logs();
    busy_force = 1'b1;
    push(1, 8'h5A, 1'b1);
    drive();
    repeat (100) tick();
    check("t5_no_accept", 32'(acc_id.size()), 32'd0);
    check("t5_no_start",  32'(txd.size()),    32'd0);
    busy_force = 1'b0;
    tick();
    check("t5_ready", 32'(s_ready), 32'h2);
    tick();
    check("t5_start", 32'(s_start), 32'd1);
    check("t5_data",  32'(s_data),  32'h5A);
    settle();

    // 6: reset while waiting on a busy transmitter with a message locked
    clear_logs();
    push(2, 8'h77, 1'b0);
    drive();
    run_until("t6_first", 1, 50);
    tick();
    reset = 1'b1;
    push(1, 8'h71, 1'b1); push(2, 8'h72, 1'b1); push(3, 8'h73, 1'b1);
    drive();
    tick();
    check("t6_locked_pre", 32'(s_locked), 32'd1);
    reset = 1'b0;
    tick();
    check("t6_start",  32'(s_start),  32'd0);
    check("t6_locked", 32'(s_locked), 32'd0);
    check("t6_ready",  32'(s_ready),  32'd0);
    run_until("t6_accepts", 4, 100);
    settle();
    check("t6_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd5);
    check("t6_id1", 32'(acc_at(1)), 32'd1);
    check("t6_id2", 32'(acc_at(2)), 32'd2);
    check("t6_id3", 32'(acc_at(3)), 32'd3);

    // Whole-run invariants
    check("err_total",   32'(err_total),   32'd1);
    check("ready_multi", 32'(ready_multi), 32'd0);
    check("ready_busy",  32'(ready_busy),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
